// File: rtl/branch_resolve.sv
// Branch resolution stage: decodes comparator flags into a taken/mispredict/redirect
// result and delivers it through a 2-entry skid buffer with saturating statistics.
module branch_resolve #(
    parameter int XLEN = 64,
    parameter int CNTW = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic            EQ,
    input  logic            LT,
    input  logic            LTu,
    input  logic            pred_taken,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            taken,
    output logic            mispredict,
    output logic            illegal,
    output logic [XLEN-1:0] redirect_pc,
    output logic [CNTW-1:0] branch_cnt,
    output logic [CNTW-1:0] mispred_cnt
);

    typedef struct packed {
        logic            taken;
        logic            mispredict;
        logic            illegal;
        logic [XLEN-1:0] rpc;
    } res_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t          state_q;
    logic            out_valid_q;
    logic            in_ready_q;
    res_t            or_q;
    res_t            sk_q;
    logic [CNTW-1:0] branch_cnt_q;
    logic [CNTW-1:0] mispred_cnt_q;

    res_t res_d;
    logic accept;
    logic drain;

    function automatic res_t resolve(input logic [2:0] f3, input logic eq, input logic lt,
                                     input logic ltu, input logic pred,
                                     input logic [XLEN-1:0] pc_v, input logic [XLEN-1:0] tgt_v);
        res_t r;
        r.illegal = 1'b0;
        case (f3)
            3'b000:  r.taken = eq;
            3'b001:  r.taken = ~eq;
            3'b100:  r.taken = lt;
            3'b101:  r.taken = ~lt;
            3'b110:  r.taken = ltu;
            3'b111:  r.taken = ~ltu;
            default: begin
                r.taken   = 1'b0;
                r.illegal = 1'b1;
            end
        endcase
        r.mispredict = r.taken ^ pred;
        // Fall-through address wraps naturally at 2^XLEN.
        r.rpc = r.taken ? tgt_v : pc_v + XLEN'(4);
        return r;
    endfunction

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] c);
        return (&c) ? c : c + CNTW'(1);
    endfunction

    assign res_d  = resolve(funct3, EQ, LT, LTu, pred_taken, pc, target);
    assign accept = in_valid & in_ready_q;
    assign drain  = out_valid_q & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= EMPTY;
            out_valid_q   <= 1'b0;
            in_ready_q    <= 1'b1;
            or_q          <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            // A drain completes even when flush kills the rest of the buffer.
            if (drain) begin
                branch_cnt_q <= sat_inc(branch_cnt_q);
                if (or_q.mispredict)
                    mispred_cnt_q <= sat_inc(mispred_cnt_q);
            end
            if (flush) begin
                state_q     <= EMPTY;
                out_valid_q <= 1'b0;
                in_ready_q  <= 1'b1;
            end else begin
                case (state_q)
                    EMPTY: begin
                        if (accept) begin
                            or_q        <= res_d;
                            state_q     <= ONE;
                            out_valid_q <= 1'b1;
                        end
                    end
                    ONE: begin
                        if (accept && drain) begin
                            or_q <= res_d;
                        end else if (accept) begin
                            sk_q       <= res_d;
                            state_q    <= FULL;
                            in_ready_q <= 1'b0;
                        end else if (drain) begin
                            state_q     <= EMPTY;
                            out_valid_q <= 1'b0;
                        end
                    end
                    FULL: begin
                        if (drain) begin
                            or_q       <= sk_q;
                            state_q    <= ONE;
                            in_ready_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q     <= EMPTY;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign taken       = or_q.taken;
    assign mispredict  = or_q.mispredict;
    assign illegal     = or_q.illegal;
    assign redirect_pc = or_q.rpc;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: doc/branch_resolve.md
# branch_resolve

Pipeline stage directly downstream of the 64-bit comparator tree. Consumes the EQ/LT/LTu flags with the branch funct3, predicted direction, PC and target. Produces the registered taken decision, the mispredict flag and the redirect PC. Decouples comparator and fetch-redirect timing with a valid/ready handshake, a 2-entry skid buffer and saturating branch/mispredict counters.

## Interface
- XLEN, 64, PC/target width
- CNTW, 32, width of statistics counters
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- flush  in  1  synchronous kill of all buffered entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry this cycle
- funct3  in  3  branch type (RISC-V B-format encoding)
- EQ  in  1  A == B from comparator tree
- LT  in  1  signed A < B
- LTu  in  1  unsigned A < B
- pred_taken  in  1  fetch-stage prediction
- pc  in  XLEN  branch PC
- target  in  XLEN  branch target (PC + imm)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- taken  out  1  resolved direction
- mispredict  out  1  taken != pred_taken
- illegal  out  1  funct3 is 010 or 011
- redirect_pc  out  XLEN  taken ? target : pc + 4 (mod 2^XLEN)
- branch_cnt  out  CNTW  completed branches, saturating
- mispred_cnt  out  CNTW  completed mispredicts, saturating

## Operation
- Decode, computed at input:
  - 000 BEQ = EQ
  - 001 BNE = ~EQ
  - 100 BLT = LT
  - 101 BGE = ~LT
  - 110 BLTU = LTu
  - 111 BGEU = ~LTu
  - 010/011: taken=0, illegal=1, mispredict = pred_taken
- The result tuple {taken, mispredict, illegal, redirect_pc} is computed combinationally from the inputs and stored in the buffer. Outputs come only from registers.
- Buffer: output register OR (drives out_*) plus skid register SK. States:
  - EMPTY: OR and SK invalid.
  - ONE: OR valid, SK invalid.
  - FULL: OR and SK valid.
- in_ready = ~SK valid, i.e. state != FULL. It is registered, not dependent on out_ready.
- Accept = in_valid & in_ready. Drain = out_valid & out_ready.
- Transitions:
  - EMPTY + accept → ONE.
  - ONE + accept, no drain → FULL; the new entry goes to SK.
  - ONE + accept + drain → ONE; the new entry replaces OR.
  - ONE + drain, no accept → EMPTY.
  - FULL + drain → ONE; SK moves to OR. No accept is possible in FULL.
- Order is strictly FIFO. No entry is dropped or duplicated except by flush or reset.
- Counters: on each drain, branch_cnt += 1, and mispred_cnt += 1 if mispredict. Illegal entries count in both when mispredict. Each counter saturates at 2^CNTW−1.
- flush: the next state is EMPTY and a same-cycle accept is discarded. A same-cycle drain still counts because it completed. in_ready is 1 next cycle. Counters are not cleared.
- reset has priority over flush.

## Timing
- Latency: accept in cycle N → out_valid in cycle N+1. Throughput is 1/cycle with out_ready held high.
- Reset values:
  - in_ready=1, out_valid=0
  - taken=0, mispredict=0, illegal=0, redirect_pc=0
  - branch_cnt=0, mispred_cnt=0
  - state EMPTY
- Reset asserted mid-operation discards all entries on the next edge, with no counter update that cycle.
- When out_valid=1 and out_ready=0, all out_* fields are held stable until drain.
- in_ready is deasserted the cycle after the buffer becomes FULL, and reasserted the cycle after a drain from FULL.
- redirect_pc wraps: pc = 2^XLEN−4, not taken → 0.

## Test plan
- BEQ, EQ=1, pred_taken=0, pc=0x1000, target=0x2000, out_ready=1 → next cycle out_valid=1, taken=1, mispredict=1, redirect_pc=0x2000, then mispred_cnt=1, branch_cnt=1.
- Sweep all 8 funct3 × EQ/LT/LTu combos (EQ=1 forces LT=LTu=0) → taken matches the decode list; 010/011 give illegal=1, taken=0, redirect_pc=pc+4.
- Backpressure: out_ready=0, send entries E1,E2,E3 → in_ready drops after E2, and E3 is held upstream. Raise out_ready → E1,E2,E3 emerge in order on consecutive cycles with fields unchanged while stalled.
- Flush in FULL state with in_valid=1, out_ready=1 → only the draining OR entry counts; next cycle out_valid=0, in_ready=1, and no stale entries ever appear.
- Saturation: CNTW=4, 20 mispredicting drains → branch_cnt=mispred_cnt=15, no wrap. pc=0xFFFF_FFFF_FFFF_FFFC not taken → redirect_pc=0.
- Assert reset for 1 cycle while FULL → all outputs at reset values next cycle, in_ready=1, and subsequent traffic resumes normally.
